// File: rtl/affichage_pkg.sv
// Shared encodings for the 3-digit multiplexed 7-segment display stage:
// digit index, segment glyphs ({g,f,e,d,c,b,a}, active-high) and active-low anodes.
package affichage_pkg;

  typedef enum logic [1:0] {
    UNITE    = 2'd0,
    DIZAINE  = 2'd1,
    CENTAINE = 2'd2
  } digit_idx_t;

  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_E   = 7'b1111001;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_ALL = 7'b1111111;

  localparam logic [2:0] AN_OFF      = 3'b111;
  localparam logic [2:0] AN_UNITE    = 3'b110;
  localparam logic [2:0] AN_DIZAINE  = 3'b101;
  localparam logic [2:0] AN_CENTAINE = 3'b011;

  function automatic logic [2:0] an_of(input digit_idx_t idx);
    case (idx)
      UNITE:    an_of = AN_UNITE;
      DIZAINE:  an_of = AN_DIZAINE;
      CENTAINE: an_of = AN_CENTAINE;
      default:  an_of = AN_OFF;
    endcase
  endfunction

endpackage

// File: rtl/affichage_7seg_mux_bcd_vers_7seg.sv
// Combinational BCD to 7-segment glyph decoder; codes 10-15 map to the error glyph E.
module bcd_vers_7seg
  import affichage_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] glyph
);

  always_comb begin
    case (bcd)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_E;
    endcase
  end

endmodule

// File: rtl/affichage_7seg_mux.sv
// Time-multiplexed 3-digit common-anode display driver with per-frame input snapshot,
// guard cycle per slot and leading-digit blanking. Optional macro: LAMP_TEST_EN.
module affichage_7seg_mux
  import affichage_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd100,
  input  logic [3:0] bcd10,
  input  logic [3:0] bcd1,
  input  logic       en0,
  input  logic       en1,
`ifdef LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  digit_idx_t    idx, idx_nxt;
  logic [3:0]    s100, s10, s1, s100_nxt, s10_nxt, s1_nxt;
  logic          se0, se1, se0_nxt, se1_nxt;
  logic          first;
  logic          load;
  logic [3:0]    digit_nxt;
  logic [6:0]    glyph_nxt;
  logic          blank_nxt;
  logic          lamp;
  logic [6:0]    seg_nxt;
  logic [2:0]    an_nxt;

`ifdef LAMP_TEST_EN
  assign lamp = lamp_test;
`else
  assign lamp = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= UNITE;
      first <= 1'b1;
      s100  <= '0;
      s10   <= '0;
      s1    <= '0;
      se0   <= 1'b0;
      se1   <= 1'b0;
      seg   <= SEG_OFF;
      an    <= AN_OFF;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      first <= 1'b0;
      s100  <= s100_nxt;
      s10   <= s10_nxt;
      s1    <= s1_nxt;
      se0   <= se0_nxt;
      se1   <= se1_nxt;
      seg   <= seg_nxt;
      an    <= an_nxt;
    end
  end

  // Slot sequencing; the snapshot refreshes when a new frame begins (and once after reset).
  always_comb begin
    cnt_nxt = cnt + CW'(1);
    idx_nxt = idx;
    load    = first;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      case (idx)
        UNITE:    idx_nxt = DIZAINE;
        DIZAINE:  idx_nxt = CENTAINE;
        default: begin
          idx_nxt = UNITE;
          load    = 1'b1;
        end
      endcase
    end
    s100_nxt = load ? bcd100 : s100;
    s10_nxt  = load ? bcd10  : s10;
    s1_nxt   = load ? bcd1   : s1;
    se0_nxt  = load ? en0    : se0;
    se1_nxt  = load ? en1    : se1;
  end

  always_comb begin
    case (idx_nxt)
      DIZAINE:  digit_nxt = s10_nxt;
      CENTAINE: digit_nxt = s100_nxt;
      default:  digit_nxt = s1_nxt;
    endcase
  end

  bcd_vers_7seg u_dec (
    .bcd   (digit_nxt),
    .glyph (glyph_nxt)
  );

  // Outputs are registered from the upcoming state so they line up with that cycle's slot.
  always_comb begin
    blank_nxt = ((idx_nxt == DIZAINE) && !se0_nxt) || ((idx_nxt == CENTAINE) && !se1_nxt);
    seg_nxt   = glyph_nxt;
    an_nxt    = an_of(idx_nxt);
    if (lamp) begin
      seg_nxt = SEG_ALL;
    end else if (blank_nxt) begin
      seg_nxt = SEG_OFF;
      an_nxt  = AN_OFF;
    end
    if (cnt_nxt == '0) an_nxt = AN_OFF;
  end

endmodule

// File: tb/tb_affichage_7seg_mux.sv
// Bench for affichage_7seg_mux with REFRESH_DIV=4: randomized and directed stimulus
// checked against a frame-position model (cycle count since reset release).
module tb_affichage_7seg_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] bcd100 = '0, bcd10 = '0, bcd1 = '0;
  logic       en0 = 1'b0, en1 = 1'b0;
`ifdef LAMP_TEST_EN
  logic       lamp_test = 1'b0;
`endif
  logic [6:0] seg;
  logic [2:0] an;

  int checks = 0;
  int errors = 0;

  // model state: k = clock edges since reset release
  int         k = 0;
  logic [3:0] m100 = '0, m10 = '0, m1 = '0;
  logic       me0 = 1'b0, me1 = 1'b0, ml = 1'b0;

  logic [6:0] glyph_tab [0:15] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                   7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                   7'b1111111, 7'b1101111, 7'b1111001, 7'b1111001,
                                   7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001};
  logic [2:0] an_tab [0:2] = '{3'b110, 3'b101, 3'b011};

  affichage_7seg_mux #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd100    (bcd100),
    .bcd10     (bcd10),
    .bcd1      (bcd1),
    .en0       (en0),
    .en1       (en1),
`ifdef LAMP_TEST_EN
    .lamp_test (lamp_test),
`endif
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  // Frame = 12 cycles: slot = position/4, t = position%4.
  function automatic void model(input int kk, output logic [6:0] es, output logic [2:0] ea);
    int p, slot, t;
    logic [3:0] d;
    logic blank;
    p     = kk % 12;
    slot  = p / 4;
    t     = p % 4;
    d     = (slot == 0) ? m1 : ((slot == 1) ? m10 : m100);
    blank = ((slot == 1) && !me0) || ((slot == 2) && !me1);
    if (ml) begin
      es = 7'b1111111;
      ea = (t == 0) ? 3'b111 : an_tab[slot];
    end else if (blank) begin
      es = 7'b0000000;
      ea = 3'b111;
    end else begin
      es = glyph_tab[d];
      ea = (t == 0) ? 3'b111 : an_tab[slot];
    end
  endfunction

  // Advance one edge, update the model, return the expected outputs at edge+1.
  task automatic tick(output logic [6:0] es, output logic [2:0] ea);
    @(posedge clk);
    k++;
    if (k == 1 || (k % 12) == 0) begin
      m100 = bcd100; m10 = bcd10; m1 = bcd1; me0 = en0; me1 = en1;
    end
`ifdef LAMP_TEST_EN
    ml = lamp_test;
`endif
    #1;
    model(k, es, ea);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== 7'b0 || an !== 3'b111) begin
      errors++;
      $display("FAIL reset_async seg=%b an=%b expected seg=0000000 an=111", seg, an);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bcd100 = 4'($urandom_range(0, 15)); bcd10 = 4'($urandom_range(0, 15));
      bcd1 = 4'($urandom_range(0, 15)); en0 = 1'($urandom_range(0, 1)); en1 = 1'($urandom_range(0, 1));
    end
    #1;
    checks++;
    if (seg !== 7'b0 || an !== 3'b111) begin
      errors++;
      $display("FAIL reset_hold seg=%b an=%b expected seg=0000000 an=111", seg, an);
    end
    bcd100 = 4'd1; bcd10 = 4'd2; bcd1 = 4'd7; en0 = 1'b1; en1 = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    #1;
    checks++;
    if (seg !== 7'b0 || an !== 3'b111) begin
      errors++;
      $display("FAIL reset_release seg=%b an=%b expected seg=0000000 an=111", seg, an);
    end
  endtask

  task automatic test_full_display();
    logic [6:0] es;
    logic [2:0] ea;
    for (int i = 0; i < 12; i++) begin
      tick(es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        errors++;
        $display("FAIL full_display k=%0d seg=%b an=%b expected seg=%b an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] es;
    logic [2:0] ea;
    bcd1 = 4'd5; en0 = 1'b0; en1 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick(es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        errors++;
        $display("FAIL blanking k=%0d seg=%b an=%b expected seg=%b an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [6:0] es;
    logic [2:0] ea;
    bcd100 = 4'd1; bcd10 = 4'd2; bcd1 = 4'd7; en0 = 1'b1; en1 = 1'b1;
    while ((k % 12) != 5) begin
      tick(es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        errors++;
        $display("FAIL snapshot_pre k=%0d seg=%b an=%b expected seg=%b an=%b", k, seg, an, es, ea);
      end
    end
    bcd1 = 4'd3;
    for (int i = 0; i < 12; i++) begin
      tick(es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        errors++;
        $display("FAIL snapshot k=%0d seg=%b an=%b expected seg=%b an=%b", k, seg, an, es, ea);
      end
      if ((k % 12) == 1) begin
        checks++;
        if (seg !== 7'b1001111 || an !== 3'b110) begin
          errors++;
          $display("FAIL snapshot_new_units seg=%b an=%b expected seg=1001111 an=110", seg, an);
        end
      end
    end
  endtask

  task automatic test_invalid_bcd();
    logic [6:0] es;
    logic [2:0] ea;
    bcd10 = 4'hC; en0 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick(es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        errors++;
        $display("FAIL invalid_bcd k=%0d seg=%b an=%b expected seg=%b an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] es;
    logic [2:0] ea;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bcd100 = 4'($urandom_range(0, 15)); bcd10 = 4'($urandom_range(0, 15));
        bcd1 = 4'($urandom_range(0, 15)); en0 = 1'($urandom_range(0, 1)); en1 = 1'($urandom_range(0, 1));
      end
`ifdef LAMP_TEST_EN
      if ($urandom_range(0, 7) == 0) lamp_test = ~lamp_test;
`endif
      tick(es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        errors++;
        $display("FAIL random k=%0d seg=%b an=%b expected seg=%b an=%b", k, seg, an, es, ea);
      end
    end
`ifdef LAMP_TEST_EN
    lamp_test = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    logic [6:0] es;
    logic [2:0] ea;
    bcd100 = 4'd9; bcd10 = 4'd0; bcd1 = 4'd4; en0 = 1'b1; en1 = 1'b1;
    while ((k % 12) != 10) tick(es, ea);
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== 7'b0 || an !== 3'b111) begin
      errors++;
      $display("FAIL reset_mid seg=%b an=%b expected seg=0000000 an=111", seg, an);
    end
    bcd100 = 4'd6; bcd10 = 4'd8; bcd1 = 4'd2; en0 = 1'b1; en1 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    #1;
    checks++;
    if (seg !== 7'b0 || an !== 3'b111) begin
      errors++;
      $display("FAIL reset_mid_release seg=%b an=%b expected seg=0000000 an=111", seg, an);
    end
    for (int i = 0; i < 12; i++) begin
      tick(es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        errors++;
        $display("FAIL reset_mid_restart k=%0d seg=%b an=%b expected seg=%b an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_display();
    test_blanking();
    test_snapshot();
    test_invalid_bcd();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
